medidor_sched: RTL and testbench

- Sequencer that runs a frequency-meter instance across a bank of ring oscillators, one oscillator at a time.
- Drives the oscillator-select mux and the meter enable, and waits for the meter's lock.
- Captures each count and streams (index, count) results out over a valid/ready handshake.
- Sits between the host/UART control logic and the shared frequency meter plus oscillator mux.

---
 rtl/medidor_sched.sv | 219 +++++++++++++++++++++
 tb/tb_medidor_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/medidor_sched.sv
// Sweep sequencer for a shared frequency meter and a bank of ring oscillators.
// For each oscillator selected by the latched mask, in ascending index order:
// select it on the mux, let the mux settle, enable the meter until it locks
// or times out, wait for the lock to clear, then offer (index, count) on a
// valid/ready result port.
module medidor_sched #(
    parameter int N_OSC     = 8,
    parameter int SEL_WIDTH = 3,
    parameter int OUT_WIDTH = 32,
    parameter int SETTLE    = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [N_OSC-1:0]     osc_mask,
    output logic                 meas_enable,
    output logic [SEL_WIDTH-1:0] osc_sel,
    input  logic                 meas_lock,
    input  logic [OUT_WIDTH-1:0] meas_count,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SEL_WIDTH-1:0] res_index,
    output logic [OUT_WIDTH-1:0] res_count,
    output logic                 res_timeout,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int ST_W = $clog2(SETTLE + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_MEASURE,
        S_RELEASE,
        S_EMIT
    } state_t;

    typedef struct packed {
        logic                 found;
        logic [SEL_WIDTH-1:0] idx;
    } pick_t;

    // Lowest set bit of m at or above position lo; found=0 when none remains,
    // so the index can never run past N_OSC-1.
    function automatic pick_t find_from(input logic [N_OSC-1:0] m, input int lo);
        pick_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = N_OSC - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) begin
                r.found = 1'b1;
                r.idx   = SEL_WIDTH'(i);
            end
        end
        return r;
    endfunction

    state_t               state_q, state_nxt;
    logic [SEL_WIDTH-1:0] idx_q, idx_nxt;
    logic [N_OSC-1:0]     mask_q, mask_nxt;
    logic [ST_W-1:0]      settle_q, settle_nxt;
    logic [TO_W-1:0]      to_q, to_nxt;
    logic [OUT_WIDTH-1:0] cnt_q, cnt_nxt;
    logic                 tmo_q, tmo_nxt;
    logic                 err_q, err_nxt;
    logic                 done_q, done_nxt;
    logic                 from_sel_q, from_sel_nxt;
    pick_t                first_pick;
    pick_t                next_pick;

    // State register; reset returns to IDLE at once so meas_enable drops asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and next-value logic for the sweep.
    always_comb begin
        state_nxt    = state_q;
        idx_nxt      = idx_q;
        mask_nxt     = mask_q;
        settle_nxt   = settle_q;
        to_nxt       = to_q;
        cnt_nxt      = cnt_q;
        tmo_nxt      = tmo_q;
        err_nxt      = err_q;
        done_nxt     = 1'b0;
        from_sel_nxt = from_sel_q;
        first_pick   = find_from(osc_mask, 0);
        next_pick    = find_from(mask_q, int'(idx_q) + 1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_nxt = osc_mask;
                    err_nxt  = 1'b0;
                    if (first_pick.found) begin
                        idx_nxt    = first_pick.idx;
                        settle_nxt = '0;
                        state_nxt  = S_SELECT;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end

            S_SELECT: begin
                if (settle_q == ST_LAST) begin
                    settle_nxt = '0;
                    to_nxt     = '0;
                    if (meas_lock) begin
                        // Lock left over from an earlier run: clear it before measuring.
                        from_sel_nxt = 1'b1;
                        state_nxt    = S_RELEASE;
                    end else begin
                        state_nxt = S_MEASURE;
                    end
                end else begin
                    settle_nxt = settle_q + ST_W'(1);
                end
            end

            S_MEASURE: begin
                if (meas_lock) begin
                    cnt_nxt      = meas_count;
                    tmo_nxt      = 1'b0;
                    from_sel_nxt = 1'b0;
                    to_nxt       = '0;
                    state_nxt    = S_RELEASE;
                end else if (to_q == TO_LAST) begin
                    cnt_nxt      = '0;
                    tmo_nxt      = 1'b1;
                    err_nxt      = 1'b1;
                    from_sel_nxt = 1'b0;
                    to_nxt       = '0;
                    state_nxt    = S_RELEASE;
                end else begin
                    to_nxt = to_q + TO_W'(1);
                end
            end

            S_RELEASE: begin
                if (!meas_lock || (to_q == TO_LAST)) begin
                    if (meas_lock) begin
                        err_nxt = 1'b1;
                    end
                    to_nxt     = '0;
                    settle_nxt = '0;
                    state_nxt  = from_sel_q ? S_SELECT : S_EMIT;
                end else begin
                    to_nxt = to_q + TO_W'(1);
                end
            end

            S_EMIT: begin
                if (res_ready) begin
                    to_nxt = '0;
                    if (next_pick.found) begin
                        idx_nxt    = next_pick.idx;
                        settle_nxt = '0;
                        state_nxt  = S_SELECT;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sweep bookkeeping and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q      <= '0;
            mask_q     <= '0;
            settle_q   <= '0;
            to_q       <= '0;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            from_sel_q <= 1'b0;
        end else begin
            idx_q      <= idx_nxt;
            mask_q     <= mask_nxt;
            settle_q   <= settle_nxt;
            to_q       <= to_nxt;
            cnt_q      <= cnt_nxt;
            tmo_q      <= tmo_nxt;
            err_q      <= err_nxt;
            done_q     <= done_nxt;
            from_sel_q <= from_sel_nxt;
        end
    end

    assign meas_enable = (state_q == S_MEASURE);
    assign osc_sel     = idx_q;
    assign res_valid   = (state_q == S_EMIT);
    assign res_index   = idx_q;
    assign res_count   = cnt_q;
    assign res_timeout = tmo_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_medidor_sched.sv
// Bench for medidor_sched: a behavioural meter model, a per-sweep list of
// expected results derived from the mask, and directed plus random sweeps.
`timescale 1ns/1ps
module tb_medidor_sched;

    localparam int N_OSC     = 8;
    localparam int SEL_WIDTH = 3;
    localparam int OUT_WIDTH = 32;
    localparam int SETTLE    = 4;
    localparam int TIMEOUT   = 4096;

    logic                 clock      = 1'b0;
    logic                 reset_n    = 1'b0;
    logic                 start      = 1'b0;
    logic [N_OSC-1:0]     osc_mask   = '0;
    logic                 meas_lock  = 1'b0;
    logic [OUT_WIDTH-1:0] meas_count = '0;
    logic                 res_ready  = 1'b0;
    logic                 meas_enable;
    logic [SEL_WIDTH-1:0] osc_sel;
    logic                 res_valid;
    logic [SEL_WIDTH-1:0] res_index;
    logic [OUT_WIDTH-1:0] res_count;
    logic                 res_timeout;
    logic                 busy;
    logic                 done;
    logic                 err;

    medidor_sched #(
        .N_OSC(N_OSC), .SEL_WIDTH(SEL_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .osc_mask(osc_mask),
        .meas_enable(meas_enable), .osc_sel(osc_sel), .meas_lock(meas_lock),
        .meas_count(meas_count), .res_valid(res_valid), .res_ready(res_ready),
        .res_index(res_index), .res_count(res_count), .res_timeout(res_timeout),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int     idx;
        longint cnt;
        bit     tmo;
    } res_t;

    res_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         lock_lat  = 10;
    int         never_idx = -1;
    logic [7:0] cur_mask  = '0;
    int         dones, sel_bad, stall_bad, stall_cyc, busy_seen, valid_seen, last_hs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // Meter model: locks lock_lat enabled cycles after enable with count idx*100+7
    // (never for never_idx); lock clears 3 cycles after enable is removed.
    int en_cnt = 0;
    int off_cnt = 0;
    always @(posedge clock) begin
        if (meas_enable) begin
            en_cnt  <= en_cnt + 1;
            off_cnt <= 0;
            if (!meas_lock) begin
                if ((en_cnt + 1 == lock_lat) && (int'(osc_sel) != never_idx)) begin
                    meas_lock  <= 1'b1;
                    meas_count <= 32'(osc_sel) * 100 + 7;
                end else begin
                    meas_count <= $urandom;
                end
            end
        end else begin
            en_cnt <= 0;
            if (meas_lock) begin
                off_cnt <= off_cnt + 1;
                if (off_cnt + 1 == 3) meas_lock <= 1'b0;
            end else begin
                off_cnt    <= 0;
                meas_count <= $urandom;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        int         cyc = 0;
        int         en_rise = 0;
        logic       prev_en = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
        logic [2:0] prev_idx = '0;
        logic [31:0] prev_cnt = '0;
        res_t       r;
        forever begin
            @(negedge clock);
            cyc++;
            if (done) dones++;
            if (busy) busy_seen++;
            if (res_valid) valid_seen++;
            if (meas_enable && !cur_mask[osc_sel]) sel_bad++;
            if (meas_enable && !prev_en) en_rise = cyc;
            if (prev_valid && !prev_ready) begin
                if (!(res_valid && res_index == prev_idx && res_count == prev_cnt && !meas_enable))
                    stall_bad++;
            end
            if (res_valid && !res_ready) stall_cyc++;
            if (res_valid && !prev_valid && exp_q.size() > 0 && exp_q[0].tmo)
                chk("to_latency", 64'((cyc - en_rise >= TIMEOUT) && (cyc - en_rise <= TIMEOUT + 2)), 1);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_result", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("res_index", 64'(res_index), 64'(r.idx));
                    chk("res_count", 64'(res_count), 64'(r.cnt));
                    chk("res_timeout", 64'(res_timeout), 64'(r.tmo));
                end
                if (last_hs >= 0) chk("hs_gap", 64'(cyc - last_hs >= SETTLE + 2), 1);
                last_hs = cyc;
            end
            prev_en    = meas_enable;
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_idx   = res_index;
            prev_cnt   = res_count;
        end
    end

    task automatic load_expect(input logic [7:0] m, input int nev, output bit exp_err);
        res_t r;
        exp_err = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N_OSC; i++) begin
            if (m[i]) begin
                r.idx = i;
                r.tmo = (i == nev);
                r.cnt = r.tmo ? 0 : i * 100 + 7;
                if (r.tmo) exp_err = 1'b1;
                exp_q.push_back(r);
            end
        end
    endtask

    // rmode 0: ready always high; 1: random ready plus stray start pulses while busy;
    // 2: ready low for the first 50 cycles of the first result.
    task automatic sweep(input string tag, input logic [7:0] m, input int nev,
                         input int lat, input int rmode);
        int k = 0;
        int st = 0;
        bit exp_err;
        load_expect(m, nev, exp_err);
        never_idx = nev;
        lock_lat  = lat;
        cur_mask  = m;
        dones = 0; sel_bad = 0; stall_bad = 0; stall_cyc = 0;
        busy_seen = 0; valid_seen = 0; last_hs = -1;
        osc_mask  = m;
        start     = 1'b1;
        res_ready = (rmode == 0);
        @(posedge clock); #1;
        start    = 1'b0;
        osc_mask = 8'($urandom);
        while (dones == 0 && k < 20000) begin
            case (rmode)
                0: res_ready = 1'b1;
                1: begin
                    res_ready = 1'($urandom_range(0, 1));
                    start     = busy && ($urandom_range(0, 7) == 0);
                    osc_mask  = 8'($urandom);
                end
                default: begin
                    res_ready = (st >= 50);
                    if (res_valid && st < 50) st++;
                end
            endcase
            @(posedge clock); #1;
            k++;
        end
        start = 1'b0;
        chk($sformatf("%s_finished", tag), 64'(k < 20000), 1);
        repeat (3) @(posedge clock);
        #1;
        chk($sformatf("%s_done_once", tag), 64'(dones), 1);
        chk($sformatf("%s_idle", tag), 64'(busy), 0);
        chk($sformatf("%s_missing", tag), 64'(exp_q.size()), 0);
        chk($sformatf("%s_err", tag), 64'(err), 64'(exp_err));
        chk($sformatf("%s_sel", tag), 64'(sel_bad), 0);
        chk($sformatf("%s_stable", tag), 64'(stall_bad), 0);
        if (rmode == 2) chk($sformatf("%s_stall_cycles", tag), 64'(stall_cyc), 50);
    endtask

    initial begin
        int  k;
        bit  dummy;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_meas_enable", 64'(meas_enable), 0);
        chk("rst_osc_sel", 64'(osc_sel), 0);
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_res_index", 64'(res_index), 0);
        chk("rst_res_count", 64'(res_count), 0);
        chk("rst_res_timeout", 64'(res_timeout), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        sweep("all", 8'hFF, -1, 1002, 0);
        sweep("sparse", 8'hA4, -1, 1002, 0);
        sweep("stall", 8'h16, -1, 30, 2);
        sweep("tmo", 8'h0F, 3, 1002, 0);
        sweep("zero", 8'h00, -1, 10, 0);
        chk("zero_busy", 64'(busy_seen), 0);
        chk("zero_valid", 64'(valid_seen), 0);
        sweep("clr_err", 8'h81, -1, 15, 0);
        for (int i = 0; i < 6; i++)
            sweep($sformatf("rnd%0d", i), 8'($urandom_range(1, 255)),
                  $urandom_range(0, 15), $urandom_range(1, 60), 1);

        // Reset while measuring index 4.
        load_expect(8'hFF, -1, dummy);
        never_idx = -1; lock_lat = 40; cur_mask = 8'hFF; last_hs = -1;
        osc_mask = 8'hFF; start = 1'b1; res_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        k = 0;
        while (!(meas_enable && osc_sel == 3'd4) && k < 5000) begin
            @(posedge clock); #1;
            k++;
        end
        chk("mid_reach_idx4", 64'(k < 5000), 1);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_meas_enable", 64'(meas_enable), 0);
        chk("mid_busy", 64'(busy), 0);
        chk("mid_res_valid", 64'(res_valid), 0);
        chk("mid_osc_sel", 64'(osc_sel), 0);
        exp_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        sweep("after_rst", 8'h36, -1, 20, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
